// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides register-address / data widths, the hard-wired zero register and
// the FIFO entry layout used by the B-result buffer.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // One buffered mult/div result. valid=0 marks an entry superseded by a
  // younger pipeline write; it still occupies its slot until drained.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// B-result FIFO for the writeback arbiter.
// DEPTH entries of {valid, reg, data}; head/tail pointers carry an extra wrap
// bit so full and empty are distinguishable without a counter.
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   push_i/push_reg_i/push_data_i  enqueue one entry (caller guarantees !full)
//   pop_i                 dequeue head (caller guarantees !empty)
//   squash_en_i/squash_reg_i       clear valid of every entry whose reg matches
//   query1_reg_i/query2_reg_i      hazard query registers
//   full_o, empty_o       occupancy flags from registered pointers
//   head_o                current head entry
//   match1_o/match2_o     per-entry: valid entry targets query register
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  squash_en_i,
  input  logic [REG_ADDR_W-1:0] squash_reg_i,
  input  logic [REG_ADDR_W-1:0] query1_reg_i,
  input  logic [REG_ADDR_W-1:0] query2_reg_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_entry_t             head_o,
  output logic [DEPTH-1:0]      match1_o,
  output logic [DEPTH-1:0]      match2_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]        head_q, head_d;
  logic [PTR_W:0]        tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);

  assign head_o = '{valid: valid_q[head_idx], rd: rd_q[head_idx], data: data_q[head_idx]};

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    // Squash only ever targets entries already buffered; a same-cycle push
    // is set valid afterwards.
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en_i && (rd_q[i] == squash_reg_i)) valid_d[i] = 1'b0;
    end
    // Popped slots are cleared so valid implies occupied for the match logic.
    if (pop_i) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + 1'b1;
    end
    if (push_i) begin
      valid_d[tail_idx] = 1'b1;
      tail_d            = tail_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the reg/data payload is not reset; valid_q alone decides whether a
  // slot means anything, so clearing it discards all buffered results.
  always_ff @(posedge Clk) begin
    if (push_i) begin
      rd_q[tail_idx]   <= push_reg_i;
      data_q[tail_idx] <= push_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match1_o[i] = valid_q[i] && (rd_q[i] == query1_reg_i);
      match2_o[i] = valid_q[i] && (rd_q[i] == query2_reg_i);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Port A (pipeline writeback) always wins the write port; port B (mult/div,
// valid/ready) results are buffered and drained into A bubbles. Reports which
// decode source registers still have buffered writes and requests a pipeline
// stall when the FIFO head has waited MAX_WAIT cycles.
// Ports:
//   Clk, Reset                     clock, asynchronous active-high reset
//   A_Valid/A_Reg/A_Data           pipeline writeback
//   B_Valid/B_Ready/B_Reg/B_Data   mult/div result handshake
//   ReadRegister1/2, Pending1/2    decode hazard query
//   StallReq                       ask pipeline for an A bubble next cycle
//   RegWrite/WriteRegister/WriteData  register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  A_Valid,
  input  logic [REG_ADDR_W-1:0] A_Reg,
  input  logic [DATA_W-1:0]     A_Data,
  input  logic                  B_Valid,
  output logic                  B_Ready,
  input  logic [REG_ADDR_W-1:0] B_Reg,
  input  logic [DATA_W-1:0]     B_Data,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic                  Pending1,
  output logic                  Pending2,
  output logic                  StallReq,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic             fifo_full;
  logic             fifo_empty;
  wb_entry_t        head;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             push;
  logic             pop;
  logic             squash_en;

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Ready is purely registered occupancy: a same-cycle pop does not free a slot.
  assign B_Ready   = !fifo_full;
  // $0 results are acknowledged but never buffered.
  assign push      = B_Valid && B_Ready && (B_Reg != ZERO_REG);
  assign pop       = !A_Valid && !fifo_empty;
  // A is younger than anything buffered, so its write supersedes them.
  assign squash_en = A_Valid && (A_Reg != ZERO_REG);

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk          (Clk),
    .Reset        (Reset),
    .push_i       (push),
    .push_reg_i   (B_Reg),
    .push_data_i  (B_Data),
    .pop_i        (pop),
    .squash_en_i  (squash_en),
    .squash_reg_i (A_Reg),
    .query1_reg_i (ReadRegister1),
    .query2_reg_i (ReadRegister2),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .match1_o     (match1),
    .match2_o     (match2)
  );

  // Priority write mux; a squashed head drains with the write suppressed.
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = ZERO_REG;
    WriteData     = '0;
    if (A_Valid) begin
      RegWrite      = 1'b1;
      WriteRegister = A_Reg;
      WriteData     = A_Data;
    end else if (!fifo_empty && head.valid) begin
      RegWrite      = 1'b1;
      WriteRegister = head.rd;
      WriteData     = head.data;
    end
  end

  // Starvation counter: counts cycles a live head is held off, saturating.
  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (head.valid && (wait_q < WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign StallReq = (wait_q >= WAIT_W'(MAX_WAIT));

  assign Pending1 = (ReadRegister1 != ZERO_REG) && (|match1);
  assign Pending2 = (ReadRegister2 != ZERO_REG) && (|match2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        A_Valid;
  logic [4:0]  A_Reg;
  logic [31:0] A_Data;
  logic        B_Valid;
  logic        B_Ready;
  logic [4:0]  B_Reg;
  logic [31:0] B_Data;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Pending1;
  logic        Pending2;
  logic        StallReq;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .A_Valid       (A_Valid),
    .A_Reg         (A_Reg),
    .A_Data        (A_Data),
    .B_Valid       (B_Valid),
    .B_Ready       (B_Ready),
    .B_Reg         (B_Reg),
    .B_Data        (B_Data),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .Pending1      (Pending1),
    .Pending2      (Pending2),
    .StallReq      (StallReq),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Register file as seen through the DUT's write port.
  logic [31:0] shadow [32];
  always @(posedge Clk) begin
    if (!Reset && RegWrite) shadow[WriteRegister] <= WriteData;
  end

  // Model: ordered list of buffered results, each live or superseded, plus
  // the number of cycles the current live head has been held off.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t model_q[$];
  int    waited = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        model_q.delete();
        waited = 0;
        check("m_rst_ready", B_Ready, 1);
        check("m_rst_stall", StallReq, 0);
        check("m_rst_p1", Pending1, 0);
        check("m_rst_p2", Pending2, 0);
        check("m_rst_rw", RegWrite, A_Valid);
      end else begin
        bit          e_ready, e_rw, e_p1, e_p2, e_stall, idle;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        e_ready = (model_q.size() < DEPTH);
        e_stall = (waited >= MAX_WAIT);
        e_p1 = 0;
        e_p2 = 0;
        foreach (model_q[i]) begin
          if (model_q[i].live && model_q[i].rd == ReadRegister1 && ReadRegister1 != 0) e_p1 = 1;
          if (model_q[i].live && model_q[i].rd == ReadRegister2 && ReadRegister2 != 0) e_p2 = 1;
        end
        idle = 0;
        e_wr = 0;
        e_wd = 0;
        if (A_Valid) begin
          e_rw = 1; e_wr = A_Reg; e_wd = A_Data;
        end else if (model_q.size() > 0) begin
          e_rw = model_q[0].live; e_wr = model_q[0].rd; e_wd = model_q[0].data;
        end else begin
          e_rw = 0; idle = 1;
        end
        check("m_ready", B_Ready, e_ready);
        check("m_stall", StallReq, e_stall);
        check("m_p1", Pending1, e_p1);
        check("m_p2", Pending2, e_p2);
        check("m_rw", RegWrite, e_rw);
        if (e_rw || idle) begin
          check("m_wr", WriteRegister, e_wr);
          check("m_wd", WriteData, e_wd);
        end
        // Advance to the state after the coming posedge.
        if (!A_Valid && model_q.size() > 0) begin
          void'(model_q.pop_front());
          waited = 0;
        end else if (model_q.size() == 0) begin
          waited = 0;
        end else if (model_q[0].live && waited < MAX_WAIT) begin
          waited++;
        end
        if (A_Valid && A_Reg != 0) begin
          foreach (model_q[i]) begin
            if (model_q[i].rd == A_Reg) begin
              ment_t e;
              e = model_q[i];
              e.live = 0;
              model_q[i] = e;
            end
          end
        end
        if (B_Valid && e_ready && B_Reg != 0) begin
          ment_t e;
          e.rd = B_Reg; e.data = B_Data; e.live = 1;
          model_q.push_back(e);
        end
      end
    end
  end

  initial begin
    Reset = 1; A_Valid = 0; A_Reg = 0; A_Data = 0;
    B_Valid = 0; B_Reg = 0; B_Data = 0; ReadRegister1 = 0; ReadRegister2 = 0;
    #1;
    check("rst_ready", B_Ready, 1);
    check("rst_stall", StallReq, 0);
    check("rst_rw", RegWrite, 0);
    check("rst_wr", WriteRegister, 0);
    check("rst_wd", WriteData, 0);
    check("rst_p1", Pending1, 0);
    tick(); tick();
    Reset = 0;

    // 1: single B result drains the cycle after acceptance.
    B_Valid = 1; B_Reg = 5; B_Data = 32'hAAAA; ReadRegister1 = 5;
    #1;
    check("t1_ready", B_Ready, 1);
    check("t1_p1_before", Pending1, 0);
    check("t1_rw_before", RegWrite, 0);
    tick();
    B_Valid = 0;
    #1;
    check("t1_rw", RegWrite, 1);
    check("t1_wr", WriteRegister, 5);
    check("t1_wd", WriteData, 32'hAAAA);
    check("t1_p1_wait", Pending1, 1);
    tick();
    check("t1_p1_after", Pending1, 0);
    check("t1_rw_after", RegWrite, 0);

    // 2: fill under continuous A, hold a 5th offer, drain through a bubble.
    A_Valid = 1; A_Reg = 20; A_Data = 32'h2020; ReadRegister1 = 0;
    for (int i = 0; i < 4; i++) begin
      B_Valid = 1; B_Reg = 5'(10 + i); B_Data = 32'h100 + i;
      tick();
    end
    B_Reg = 14; B_Data = 32'h104;
    #1;
    check("t2_full", B_Ready, 0);
    tick();
    check("t2_full_held", B_Ready, 0);
    A_Valid = 0;
    #1;
    check("t2_bubble_wr", WriteRegister, 10);
    check("t2_bubble_wd", WriteData, 32'h100);
    check("t2_ready_pop", B_Ready, 0);
    tick();
    A_Valid = 1;
    #1;
    check("t2_ready_after", B_Ready, 1);
    tick();
    B_Valid = 0; A_Valid = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_drain_wr", WriteRegister, 5'(11 + k));
      tick();
    end
    check("t2_empty_rw", RegWrite, 0);

    // 3: younger A write to $7 squashes the buffered $7.
    B_Valid = 1; B_Reg = 7; B_Data = 1; ReadRegister1 = 7;
    tick();
    B_Valid = 0; A_Valid = 1; A_Reg = 7; A_Data = 2;
    #1;
    check("t3_p1_before", Pending1, 1);
    check("t3_a_wd", WriteData, 2);
    tick();
    A_Valid = 0;
    #1;
    check("t3_p1_after", Pending1, 0);
    check("t3_drain_rw", RegWrite, 0);
    tick();
    check("t3_reg7", shadow[7], 2);

    // 4: starvation under continuous A, then a bubble releases the stall.
    B_Valid = 1; B_Reg = 9; B_Data = 32'h99; ReadRegister1 = 0;
    tick();
    B_Valid = 0; A_Valid = 1; A_Reg = 3; A_Data = 32'h33;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("t4_stall_7", StallReq, 0);
      if (i == 8) check("t4_stall_8", StallReq, 1);
      if (i == 10) check("t4_stall_sat", StallReq, 1);
    end
    A_Valid = 0;
    #1;
    check("t4_head_wr", WriteRegister, 9);
    check("t4_head_wd", WriteData, 32'h99);
    check("t4_stall_hold", StallReq, 1);
    tick();
    check("t4_stall_drop", StallReq, 0);

    // 5: B to $0 is acknowledged and dropped.
    B_Valid = 1; B_Reg = 0; B_Data = 32'h55; ReadRegister1 = 0; ReadRegister2 = 0;
    #1;
    check("t5_ready", B_Ready, 1);
    tick();
    B_Valid = 0;
    #1;
    check("t5_rw", RegWrite, 0);
    check("t5_p1", Pending1, 0);
    check("t5_p2", Pending2, 0);
    tick();

    // 6: reset with three results queued discards them at once.
    A_Valid = 1; A_Reg = 21; A_Data = 32'h21; ReadRegister1 = 15; ReadRegister2 = 17;
    for (int i = 0; i < 3; i++) begin
      B_Valid = 1; B_Reg = 5'(15 + i); B_Data = 32'h150 + i;
      tick();
    end
    B_Valid = 0;
    #1;
    check("t6_p1_q", Pending1, 1);
    check("t6_p2_q", Pending2, 1);
    Reset = 1; A_Valid = 0;
    #1;
    check("t6_rw", RegWrite, 0);
    check("t6_ready", B_Ready, 1);
    check("t6_p1", Pending1, 0);
    check("t6_p2", Pending2, 0);
    tick(); tick();
    Reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_post_rw", RegWrite, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
